// File: rtl/quad_encoder_tx.sv
// quad_encoder_tx: quadrature encoder emulator.
// Accepts an absolute target position and steps quadA/quadB one Gray-code
// edge at a time toward it, one edge every `period` clocks. The period is
// clamped to at least MIN_PERIOD.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_target            absolute target position
//   cmd_period            clocks per quadrature edge (clamped up to MIN_PERIOD)
//   abort                 cancel the running move (honoured only while moving)
//   quadA, quadB          registered quadrature phases
//   position              registered current emitted position
//   busy                  move in progress
//   done                  one-cycle pulse when a move completes
module quad_encoder_tx #(
  parameter int unsigned POS_W      = 9,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             quadA,
  output logic             quadB,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(MIN_PERIOD);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t           state, state_next;
  logic [POS_W-1:0] target;
  logic [POS_W-1:0] pos_step;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] period_eff;
  logic [DIV_W-1:0] div_cnt;
  logic             dir_up;
  logic             accept;
  logic             edge_due;

  assign period_eff = (cmd_period < MIN_P) ? MIN_P : cmd_period;
  assign accept     = (state == IDLE) && cmd_valid;
  // An abort in the same cycle as a due edge suppresses that edge.
  assign edge_due   = (state == RUN) && !abort && (div_cnt == period);
  assign pos_step   = dir_up ? (position + POS_ONE) : (position - POS_ONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = (cmd_target == position) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (edge_due && (pos_step == target)) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state == RUN);
    done      = (state == FINISH);
  end

  // Datapath: command latch, edge divider, position and phase.
  // The phase is the Gray code of position[1:0], so quadA/quadB are
  // always reloaded from the new position rather than stepped separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target   <= '0;
      period   <= '0;
      dir_up   <= 1'b0;
      div_cnt  <= '0;
      position <= '0;
      quadA    <= 1'b0;
      quadB    <= 1'b0;
    end else begin
      if (accept) begin
        target  <= cmd_target;
        period  <= period_eff;
        dir_up  <= (cmd_target > position);
        div_cnt <= DIV_ONE;
      end else if (state == RUN && !abort) begin
        if (edge_due) begin
          position <= pos_step;
          quadA    <= pos_step[1];
          quadB    <= pos_step[1] ^ pos_step[0];
          div_cnt  <= DIV_ONE;
        end else begin
          div_cnt  <= div_cnt + DIV_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_tx.sv
module tb_quad_encoder_tx;

  localparam int POS_W = 9;
  localparam int DIV_W = 16;
  localparam int MIN_P = 4;
  localparam int POS_MAX = (1 << POS_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_target = '0;
  logic [DIV_W-1:0] cmd_period = '0;
  logic             abort = 1'b0;
  logic             quadA;
  logic             quadB;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             done;

  quad_encoder_tx #(.POS_W(POS_W), .DIV_W(DIV_W), .MIN_PERIOD(MIN_P)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_period(cmd_period), .abort(abort),
    .quadA(quadA), .quadB(quadB), .position(position), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; at a falling edge it names the rising edge just passed.
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit       is_done;
    int       pos;
    logic [1:0] ab;
    int       at;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  logic [POS_W+1:0] prev = '0;
  int   model_pos = 0;

  // Quadrature phase for a position: forward order 00,01,11,10.
  function automatic logic [1:0] phase_of(int p);
    logic [1:0] tbl [4];
    tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
    return tbl[p % 4];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change of the phase/position outputs and every done pulse
  // consumes one expected event from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if ({position, quadA, quadB} != prev) begin
        if (sbq.size() == 0) begin
          check("unexpected_edge", int'(position), -1);
        end else begin
          e = sbq.pop_front();
          check("edge_kind", int'(e.is_done), 0);
          check("edge_pos", int'(position), e.pos);
          check("edge_phase", int'({quadA, quadB}), int'(e.ab));
          check("edge_cycle", cyc, e.at);
        end
      end
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("done_kind", int'(e.is_done), 1);
          check("done_cycle", cyc, e.at);
        end
      end
    end
    prev = {position, quadA, quadB};
  end

  // Issue one move; abort_at>0 raises abort so it is sampled abort_at
  // rising edges after acceptance.
  task automatic do_move(input int tgt, input int per, input int abort_at);
    int t, p, n, dir, tmo, emitted;
    bit aborted;
    tmo = 0;
    while (!cmd_ready && tmo < 2000) begin
      @(negedge clk);
      tmo++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    cmd_valid  = 1'b1;
    cmd_target = POS_W'(tgt);
    cmd_period = DIV_W'(per);
    t   = cyc + 1;
    p   = (per < MIN_P) ? MIN_P : per;
    n   = (tgt > model_pos) ? (tgt - model_pos) : (model_pos - tgt);
    dir = (tgt > model_pos) ? 1 : -1;
    aborted = (abort_at > 0) && (n > 0) && (abort_at <= n * p);
    emitted = aborted ? ((abort_at - 1) / p) : n;
    if (emitted > n) emitted = n;
    for (int k = 1; k <= emitted; k++) begin
      sbq.push_back('{1'b0, model_pos + dir * k, phase_of(model_pos + dir * k), t + k * p});
    end
    if (!aborted) sbq.push_back('{1'b1, tgt, 2'b00, t + n * p});
    model_pos = model_pos + dir * emitted;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (aborted) begin
      while (cyc < t + abort_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_ready", int'(cmd_ready), 1);
      check("abort_busy", int'(busy), 0);
    end else begin
      if (n > 0) begin
        // A command offered mid-move must be dropped.
        @(negedge clk);
        check("run_busy", int'(busy), 1);
        check("run_ready", int'(cmd_ready), 0);
        cmd_valid  = 1'b1;
        cmd_target = POS_W'($urandom_range(0, POS_MAX));
        @(negedge clk);
        cmd_valid = 1'b0;
      end
      while (cyc < t + n * p) @(negedge clk);
      check("finish_ready", int'(cmd_ready), 0);
      check("finish_busy", int'(busy), 0);
      @(negedge clk);
      check("idle_ready", int'(cmd_ready), 1);
    end
  endtask

  initial begin
    int tgt, per, n, a;
    repeat (3) @(negedge clk);
    check("rst_quad", int'({quadA, quadB}), 0);
    check("rst_pos", int'(position), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    do_move(5, 4, 0);
    check("pos_after_5", int'(position), 5);
    do_move(2, 10, 0);
    do_move(6, 0, 0);
    do_move(3, 1, 0);
    do_move(3, 7, 0);
    do_move(0, 4, 0);
    do_move(100, 4, 37 * 4 + 2);
    check("abort_pos", int'(position), 37);
    check("abort_phase", int'({quadA, quadB}), 1);
    repeat (10) @(negedge clk);
    do_move(40, 4, 0);

    // abort while idle is ignored; the monitor flags any output change
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", int'(cmd_ready), 1);

    do_move(40, 5, 5);
    do_move(POS_MAX, 4, 0);
    check("pos_max", int'(position), POS_MAX);
    do_move(POS_MAX - 3, 6, 12);
    do_move(0, 4, 0);

    for (int i = 0; i < 25; i++) begin
      tgt = model_pos + int'($urandom_range(0, 60)) - 30;
      if (tgt < 0) tgt = 0;
      if (tgt > POS_MAX) tgt = POS_MAX;
      per = int'($urandom_range(0, 9));
      n = (tgt > model_pos) ? (tgt - model_pos) : (model_pos - tgt);
      a = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        a = int'($urandom_range(1, n * ((per < MIN_P) ? MIN_P : per)));
      end
      do_move(tgt, per, a);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    check("final_pos", int'(position), model_pos);

    // asynchronous reset in the middle of a move
    mon_en = 1'b0;
    cmd_valid  = 1'b1;
    cmd_target = POS_W'(300);
    cmd_period = DIV_W'(4);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pos", int'(position), 0);
    check("midrst_quad", int'({quadA, quadB}), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
